// File: rtl/x_ram_noread_if.sv
// Control and edge-position bundle between the pipe scroller and its
// consumers (VGA renderer, collision checker, Y-height ROM).
interface x_ram_noread_if;
  logic       Start;
  logic       Stop;
  logic       Ack;
  logic [2:0] out_pipe;
  logic [3:0] Score;
  logic [9:0] X_Edge_OO_L, X_Edge_O1_L, X_Edge_O2_L, X_Edge_O3_L, X_Edge_O4_L;
  logic [9:0] X_Edge_OO_R, X_Edge_O1_R, X_Edge_O2_R, X_Edge_O3_R, X_Edge_O4_R;
  logic       Q_Initial, Q_Count, Q_Stop;

  modport master (
    output Start, Stop, Ack,
    input  out_pipe, Score,
    input  X_Edge_OO_L, X_Edge_O1_L, X_Edge_O2_L, X_Edge_O3_L, X_Edge_O4_L,
    input  X_Edge_OO_R, X_Edge_O1_R, X_Edge_O2_R, X_Edge_O3_R, X_Edge_O4_R,
    input  Q_Initial, Q_Count, Q_Stop
  );

  modport slave (
    input  Start, Stop, Ack,
    output out_pipe, Score,
    output X_Edge_OO_L, X_Edge_O1_L, X_Edge_O2_L, X_Edge_O3_L, X_Edge_O4_L,
    output X_Edge_OO_R, X_Edge_O1_R, X_Edge_O2_R, X_Edge_O3_R, X_Edge_O4_R,
    output Q_Initial, Q_Count, Q_Stop
  );
endinterface

// File: rtl/x_ram_noread.sv
// Flappy pipe scroller: five pipe X positions moving left, leftmost recycled to
// the right end with a score count. XRAM_SCORE_SAT_EN makes Score saturate at 9.
module x_ram_noread #(
  parameter int unsigned START_X = 320,
  parameter int unsigned SPACING = 160,
  parameter int unsigned PIPE_W  = 40,
  parameter int unsigned STEP    = 1
) (
  input  logic           clk,
  input  logic           reset,
  x_ram_noread_if.slave  bus
);

  localparam int unsigned XW    = 10;
  localparam int unsigned NSLOT = 5;
  localparam int unsigned SW    = 4;
  localparam int unsigned PW    = 3;
  localparam logic [SW-1:0] SCORE_MAX = SW'(9);

  // One-hot encoding so the state bits are the Q_* indicators directly
  typedef enum logic [2:0] {
    S_INITIAL = 3'b001,
    S_COUNT   = 3'b010,
    S_STOP    = 3'b100
  } state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x_l [NSLOT];
  logic [SW-1:0]   score;
  logic [SW-1:0]   score_inc;
  logic [PW-1:0]   pipe;
  logic            do_reload, do_move, do_shift;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INITIAL;
    else       state <= state_nxt;
  end

  // Next-state logic; each state listens to exactly one input
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INITIAL: if (bus.Start) state_nxt = S_COUNT;
      S_COUNT:   if (bus.Stop)  state_nxt = S_STOP;
      S_STOP:    if (bus.Ack)   state_nxt = S_INITIAL;
      default:                  state_nxt = S_INITIAL;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    bus.Q_Initial = state[0];
    bus.Q_Count   = state[1];
    bus.Q_Stop    = state[2];
    do_reload     = 1'b0;
    do_move       = 1'b0;
    do_shift      = 1'b0;
    unique case (state)
      S_INITIAL: do_reload = 1'b1;
      S_COUNT: begin
        if (!bus.Stop) begin
          if (x_l[0] >= XW'(STEP)) do_move  = 1'b1;
          else                     do_shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef XRAM_SCORE_SAT_EN
  assign score_inc = (score == SCORE_MAX) ? SCORE_MAX : score + SW'(1);
`else
  assign score_inc = (score == SCORE_MAX) ? SW'(0) : score + SW'(1);
`endif

  // Pipe positions, score and pattern index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NSLOT; k++)
        x_l[k] <= XW'(START_X + k * SPACING);
      score <= '0;
      pipe  <= '0;
    end else if (do_reload) begin
      for (int unsigned k = 0; k < NSLOT; k++)
        x_l[k] <= XW'(START_X + k * SPACING);
      score <= '0;
      pipe  <= '0;
    end else if (do_shift) begin
      for (int unsigned k = 0; k < NSLOT - 1; k++)
        x_l[k] <= x_l[k+1] - XW'(STEP);
      x_l[NSLOT-1] <= x_l[NSLOT-1] - XW'(STEP) + XW'(SPACING);
      score <= score_inc;
      pipe  <= pipe + PW'(1);
    end else if (do_move) begin
      for (int unsigned k = 0; k < NSLOT; k++)
        x_l[k] <= x_l[k] - XW'(STEP);
    end
  end

  assign bus.Score    = score;
  assign bus.out_pipe = pipe;

  assign bus.X_Edge_OO_L = x_l[0];
  assign bus.X_Edge_O1_L = x_l[1];
  assign bus.X_Edge_O2_L = x_l[2];
  assign bus.X_Edge_O3_L = x_l[3];
  assign bus.X_Edge_O4_L = x_l[4];

  // Right edges cannot overflow 10 bits under legal parameters
  assign bus.X_Edge_OO_R = x_l[0] + XW'(PIPE_W);
  assign bus.X_Edge_O1_R = x_l[1] + XW'(PIPE_W);
  assign bus.X_Edge_O2_R = x_l[2] + XW'(PIPE_W);
  assign bus.X_Edge_O3_R = x_l[3] + XW'(PIPE_W);
  assign bus.X_Edge_O4_R = x_l[4] + XW'(PIPE_W);

endmodule

// File: tb/tb_x_ram_noread.sv
// Directed self-checking bench for the x_ram_noread pipe scroller.
module tb_x_ram_noread;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  x_ram_noread_if bus ();

  x_ram_noread dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_initial(input string tag);
    check({tag, " Q_Initial"}, int'(bus.Q_Initial), 1);
    check({tag, " Q_Count"},   int'(bus.Q_Count),   0);
    check({tag, " Q_Stop"},    int'(bus.Q_Stop),    0);
    check({tag, " L0"}, int'(bus.X_Edge_OO_L), 320);
    check({tag, " L1"}, int'(bus.X_Edge_O1_L), 480);
    check({tag, " L2"}, int'(bus.X_Edge_O2_L), 640);
    check({tag, " L3"}, int'(bus.X_Edge_O3_L), 800);
    check({tag, " L4"}, int'(bus.X_Edge_O4_L), 960);
    check({tag, " Score"},    int'(bus.Score),    0);
    check({tag, " out_pipe"}, int'(bus.out_pipe), 0);
  endtask

  initial begin
    int exp_score;
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    bus.Ack   = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Idle after reset
    check_initial("rst");
    check("rst R0", int'(bus.X_Edge_OO_R), 360);
    check("rst R1", int'(bus.X_Edge_O1_R), 520);
    check("rst R2", int'(bus.X_Edge_O2_R), 680);
    check("rst R3", int'(bus.X_Edge_O3_R), 840);
    check("rst R4", int'(bus.X_Edge_O4_R), 1000);
    bus.Stop = 1'b1;  // ignored in INITIAL
    bus.Ack  = 1'b1;
    tick(10);
    bus.Stop = 1'b0;
    bus.Ack  = 1'b0;
    check_initial("idle10");

    // Start: no movement on the transition edge
    bus.Start = 1'b1;
    tick(1);
    bus.Start = 1'b0;
    check("start Q_Count", int'(bus.Q_Count), 1);
    check("start L0", int'(bus.X_Edge_OO_L), 320);
    bus.Ack = 1'b1;  // ignored in COUNT
    tick(10);
    bus.Ack = 1'b0;
    check("cnt10 L0", int'(bus.X_Edge_OO_L), 310);
    check("cnt10 L4", int'(bus.X_Edge_O4_L), 950);
    check("cnt10 Q_Count", int'(bus.Q_Count), 1);

    tick(310);
    check("cnt320 L0", int'(bus.X_Edge_OO_L), 0);
    check("cnt320 L4", int'(bus.X_Edge_O4_L), 640);
    check("cnt320 Score", int'(bus.Score), 0);
    tick(1);
    check("shift L0", int'(bus.X_Edge_OO_L), 159);
    check("shift R0", int'(bus.X_Edge_OO_R), 199);
    check("shift L3", int'(bus.X_Edge_O3_L), 639);
    check("shift L4", int'(bus.X_Edge_O4_L), 799);
    check("shift Score", int'(bus.Score), 1);
    check("shift out_pipe", int'(bus.out_pipe), 1);

    // Stop freezes, no move on the stop edge
    bus.Stop = 1'b1;
    tick(1);
    check("stop Q_Stop", int'(bus.Q_Stop), 1);
    check("stop L0", int'(bus.X_Edge_OO_L), 159);
    bus.Start = 1'b1;  // ignored in STOP
    tick(20);
    bus.Stop  = 1'b0;
    bus.Start = 1'b0;
    check("stop20 Q_Stop", int'(bus.Q_Stop), 1);
    check("stop20 L0", int'(bus.X_Edge_OO_L), 159);
    check("stop20 L4", int'(bus.X_Edge_O4_L), 799);
    check("stop20 Score", int'(bus.Score), 1);
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
    check("ack Q_Initial", int'(bus.Q_Initial), 1);
    check("ack L0 held", int'(bus.X_Edge_OO_L), 159);
    tick(1);
    check_initial("reload");

    // Ten recycles: first after 321 clocks, then every 160
    bus.Start = 1'b1;
    tick(1);
    bus.Start = 1'b0;
    tick(321);
    check("rec1 Score", int'(bus.Score), 1);
    check("rec1 L0", int'(bus.X_Edge_OO_L), 159);
    for (int i = 2; i <= 10; i++) begin
      tick(160);
`ifdef XRAM_SCORE_SAT_EN
      exp_score = (i > 9) ? 9 : i;
`else
      exp_score = i % 10;
`endif
      check($sformatf("rec%0d Score", i), int'(bus.Score), exp_score);
      check($sformatf("rec%0d out_pipe", i), int'(bus.out_pipe), i % 8);
      check($sformatf("rec%0d L0", i), int'(bus.X_Edge_OO_L), 159);
      check($sformatf("rec%0d L4", i), int'(bus.X_Edge_O4_L), 799);
    end

    // Asynchronous reset between clock edges
    tick(7);
    #2 reset = 1'b1;
    #1;
    check_initial("async");
    tick(2);
    reset = 1'b0;
    tick(1);
    check("post Q_Initial", int'(bus.Q_Initial), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
